// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - Philips I2S stereo transmit serializer with frame holding register
// Optional feature macro: I2S_TX_UNDERRUN_REPEAT_EN (repeat last frame on underrun instead of silence)
module i2s_tx_serializer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    bclk,
  input  logic [SAMPLE_WIDTH-1:0] s_left,
  input  logic [SAMPLE_WIDTH-1:0] s_right,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int CW         = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] LAST_C = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] SLOT_C = CW'(SLOT_WIDTH);

  logic                  bclk_q;
  logic                  fall;
  logic                  frame_start;
  logic                  accept;
  logic                  load_hold;
  logic [CW-1:0]         cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] hold_frame;
  logic                  hold_full;
  logic [FRAME_BITS-1:0] in_frame;
  logic [FRAME_BITS-1:0] sub_frame;

  assign fall        = bclk_q & ~bclk;
  assign frame_start = fall & enable & (cnt == '0);
  assign load_hold   = frame_start & hold_full;
  assign accept      = s_valid & ~hold_full;
  assign s_ready     = ~hold_full;

  // Pack incoming samples left-aligned in their slots, zero padded below.
  always_comb begin
    in_frame = '0;
    in_frame[FRAME_BITS-1 -: SAMPLE_WIDTH] = s_left;
    in_frame[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = s_right;
  end

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [FRAME_BITS-1:0] last_frame;

  assign sub_frame = last_frame;

  // Remember the most recent real frame so an underrun can repeat it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_frame <= '0;
    end else if (load_hold) begin
      last_frame <= hold_frame;
    end
  end
`else
  assign sub_frame = '0;
`endif

  // Register the divider's bit clock so its falling edge can be detected.
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_q <= 1'b0;
    end else begin
      bclk_q <= bclk;
    end
  end

  // Bit counter and shift register; sdata lags shreg by one bit time (I2S one-bit delay).
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt   <= '0;
      shreg <= '0;
      sdata <= 1'b0;
      lrclk <= 1'b0;
    end else if (fall) begin
      lrclk <= (cnt >= SLOT_C);
      sdata <= shreg[FRAME_BITS-1];
      cnt   <= (cnt == LAST_C) ? '0 : cnt + CW'(1);
      if (cnt == '0) begin
        shreg <= hold_full ? hold_frame : sub_frame;
      end else begin
        shreg <= shreg << 1;
      end
    end
  end

  // Underrun pulses in the cycle the substitute frame is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
    end else begin
      underrun <= frame_start & ~hold_full;
    end
  end

  // Single-entry holding register; accept and load never coincide since s_ready gates accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full  <= 1'b0;
      hold_frame <= '0;
    end else if (accept) begin
      hold_full  <= 1'b1;
      hold_frame <= in_frame;
    end else if (load_hold) begin
      hold_full  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - directed self-checking bench for i2s_tx_serializer
module tb_i2s_tx_serializer;

  localparam int SW = 24;
  localparam int SL = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          bclk = 1'b0;
  logic          s_valid = 1'b0;
  logic [SW-1:0] s_left = '0;
  logic [SW-1:0] s_right = '0;
  logic          s_ready;
  logic          lrclk;
  logic          sdata;
  logic          underrun;

  i2s_tx_serializer #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SL)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .bclk     (bclk),
    .s_left   (s_left),
    .s_right  (s_right),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          div = 0;
  int          cnt = 0;
  int          cur_c = 0;
  bit          fall_pend = 0;
  bit          cur_valid = 0;
  bit          word_started = 0;
  bit          rdy_prev = 0;
  bit          feed_en = 0;
  bit          chk_ready_load = 0;
  int          ur_cnt = 0;
  int          ready_err = 0;
  int          lr_err = 0;
  int          feed_k = 0;
  logic [63:0] word = '0;
  logic [63:0] rx_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_frame(input logic [23:0] l, input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  // One clk step: observe the posedge that just happened, then drive bclk (divide by 8).
  task automatic tick();
    @(negedge clk);
    if (underrun) ur_cnt++;
    if (!rst && s_valid && rdy_prev) begin
      if (feed_en) begin
        feed_k++;
        s_left  = 24'h100000 + 24'(feed_k);
        s_right = 24'hA00000 + 24'(feed_k);
      end else begin
        s_valid = 1'b0;
      end
    end
    if (rst || !enable) begin
      cnt = 0; cur_valid = 0; word_started = 0; fall_pend = 0;
    end else if (fall_pend) begin
      fall_pend = 0;
      cur_c = cnt;
      cur_valid = 1;
      cnt = (cnt == 63) ? 0 : cnt + 1;
      if (cur_c == 0 && chk_ready_load && !s_ready) ready_err++;
    end
    rdy_prev = s_ready;
    div++;
    if (div == 4) begin
      div = 0;
      if (bclk) begin
        bclk = 1'b0;
        fall_pend = 1;
      end else begin
        bclk = 1'b1;
        if (cur_valid) begin
          if (lrclk !== (cur_c >= 32)) lr_err++;
          if (cur_c == 0) begin
            if (word_started) begin
              word[0] = sdata;
              rx_q.push_back(word);
            end
            word_started = 0;
          end else begin
            if (cur_c == 1) begin
              word_started = 1;
              word = '0;
            end
            if (word_started) word[64-cur_c] = sdata;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; feed_en = 0; chk_ready_load = 0;
    tick(); tick();
    rst = 1'b0;
    rx_q.delete();
    ur_cnt = 0; ready_err = 0; lr_err = 0;
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin tick(); t++; end
    if (rx_q.size() < n) check({tag, "_timeout"}, 64'(rx_q.size()), 64'(n));
  endtask

  task automatic wait_pend_c(input int c, input int budget, input string tag);
    int t = 0;
    while (!(fall_pend && cnt == c) && t < budget) begin tick(); t++; end
    if (!(fall_pend && cnt == c)) check({tag, "_timeout"}, 64'(cnt), 64'(c));
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int t = 0;
    while (!s_ready && t < budget) begin tick(); t++; end
    if (!s_ready) check({tag, "_timeout"}, 64'(s_ready), 64'(1));
  endtask

  task automatic offer(input logic [23:0] l, input logic [23:0] r);
    s_left = l; s_right = r; s_valid = 1'b1;
    tick();
  endtask

  initial begin
    logic [63:0] fa;
    logic [63:0] fb;

    // Reset state
    do_reset();
    tick();
    check("rst_s_ready", 64'(s_ready), 64'(1));
    check("rst_sdata", 64'(sdata), 64'(0));
    check("rst_lrclk", 64'(lrclk), 64'(0));
    check("rst_underrun", 64'(underrun), 64'(0));

    // Single frame, then underrun at the second boundary
    do_reset();
    chk_ready_load = 1;
    fa = mk_frame(24'h800001, 24'h7FFFFE);
    offer(24'h800001, 24'h7FFFFE);
    check("single_ready_low", 64'(s_ready), 64'(0));
    enable = 1'b1;
    wait_words(1, 1500, "single_w0");
    check("single_frame", rx_q[0], fa);
    check("single_left_msb_c1", 64'(rx_q[0][63]), 64'(1));
    check("single_right_msb_c33", 64'(rx_q[0][31]), 64'(0));
    check("underrun_count", 64'(ur_cnt), 64'(1));
    wait_words(2, 1500, "single_w1");
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    check("underrun_repeat", rx_q[1], fa);
`else
    check("underrun_silence", rx_q[1], 64'h0);
`endif
    check("single_ready_after_load", 64'(ready_err), 64'(0));
    check("single_lrclk", 64'(lr_err), 64'(0));

    // Back-to-back streaming
    do_reset();
    chk_ready_load = 1;
    feed_k = 0;
    feed_en = 1;
    s_left = 24'h100000; s_right = 24'hA00000; s_valid = 1'b1;
    enable = 1'b1;
    wait_words(4, 4000, "stream");
    for (int i = 0; i < 4; i++)
      check($sformatf("stream_frame%0d", i), rx_q[i], mk_frame(24'h100000 + 24'(i), 24'hA00000 + 24'(i)));
    check("stream_no_underrun", 64'(ur_cnt), 64'(0));
    check("stream_ready_after_load", 64'(ready_err), 64'(0));
    check("stream_lrclk", 64'(lr_err), 64'(0));
    feed_en = 0; s_valid = 1'b0;

    // Accept coincides with an empty-register c=0 load
    do_reset();
    s_left = 24'h123456; s_right = 24'hABCDEF;
    enable = 1'b1;
    wait_pend_c(0, 50, "simul_c0");
    s_valid = 1'b1;
    tick();
    check("simul_underrun", 64'(ur_cnt), 64'(1));
    check("simul_ready_low", 64'(s_ready), 64'(0));
    wait_words(2, 1500, "simul");
    check("simul_sub_frame", rx_q[0], 64'h0);
    check("simul_next_frame", rx_q[1], mk_frame(24'h123456, 24'hABCDEF));

    // Enable drop at c=40 with a frame held
    do_reset();
    fb = mk_frame(24'h5A5A5A, 24'h3C3C3C);
    offer(24'h00F0F0, 24'hFFFFFF);
    enable = 1'b1;
    wait_ready(100, "endrop_load");
    offer(24'h5A5A5A, 24'h3C3C3C);
    wait_pend_c(40, 600, "endrop_c40");
    check("endrop_lrclk_before", 64'(lrclk), 64'(1));
    enable = 1'b0;
    repeat (3) tick();
    check("endrop_sdata", 64'(sdata), 64'(0));
    check("endrop_lrclk", 64'(lrclk), 64'(0));
    check("endrop_held", 64'(s_ready), 64'(0));
    repeat (20) tick();
    enable = 1'b1;
    wait_words(1, 1500, "endrop");
    check("endrop_frame", rx_q[0], fb);
    check("endrop_lrclk_seq", 64'(lr_err), 64'(0));

    // Reset at c=20 with the holding register full
    do_reset();
    offer(24'h0F0F0F, 24'h111111);
    enable = 1'b1;
    wait_ready(100, "rstmid_load");
    offer(24'h777777, 24'h999999);
    wait_pend_c(20, 600, "rstmid_c20");
    rst = 1'b1;
    tick();
    check("rstmid_sdata", 64'(sdata), 64'(0));
    check("rstmid_lrclk", 64'(lrclk), 64'(0));
    check("rstmid_underrun", 64'(underrun), 64'(0));
    check("rstmid_s_ready", 64'(s_ready), 64'(1));
    rst = 1'b0;
    rx_q.delete();
    wait_words(2, 1500, "rstmid");
    check("rstmid_frame0", rx_q[0], 64'h0);
    check("rstmid_frame1", rx_q[1], 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Serializes stereo PCM frames into a Philips I2S data stream (sdata, lrclk). It sits directly downstream of the bit-clock divider and consumes that divider's registered bit clock as a level input in the same clk domain. It accepts one stereo frame at a time through a valid/ready holding register. It substitutes a frame and flags underrun when no sample is ready at a frame boundary.

## Interface
- SAMPLE_WIDTH, 24: bits per channel sample; must be ≤ SLOT_WIDTH.
- SLOT_WIDTH, 32: bit clocks per channel slot; frame = 2*SLOT_WIDTH bit clocks.
- clk  in  1  system clock; bclk is generated from it.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  run serializer; low = idle.
- bclk  in  1  bit clock level, registered in the clk domain by the divider; high/low phases ≥ 2 clk.
- s_left  in  SAMPLE_WIDTH  left sample, two's complement.
- s_right  in  SAMPLE_WIDTH  right sample.
- s_valid  in  1  frame on s_left/s_right valid.
- s_ready  out  1  holding register empty.
- lrclk  out  1  word select: 0 = left, 1 = right.
- sdata  out  1  serial data, MSB first.
- underrun  out  1  one-clk pulse: frame boundary reached with holding register empty.

## Operation
- bclk_q is bclk registered; fall = bclk_q & ~bclk. All serializer state advances only on fall cycles while enable=1.
- Bit counter c runs 0..2*SLOT_WIDTH-1 and wraps to 0. It increments on each fall.
- On each fall with counter value c:
  - lrclk <= (c >= SLOT_WIDTH).
  - sdata <= shreg[MSB].
  - If c≠0: shreg <= shreg << 1.
  - If c=0: shreg is loaded with the next frame, {s_left, zero pad, s_right, zero pad}, each half SLOT_WIDTH bits, sample left-aligned in its slot.
- This gives the standard one-bit I2S delay: the left MSB appears at c=1, and the final frame bit appears at the next frame's c=0.
- Frame source at c=0:
  - If the holding register is full: load from it and clear it.
  - Else: load the substitute frame and pulse underrun.
- Holding register: accepted when s_valid & s_ready. s_ready = ~hold_full.
- Simultaneous accept and c=0 fall with the register empty: underrun is taken, and the accepted frame lands in the holding register for the next frame.
- Load and accept cannot coincide on a full register, because s_ready is low.
- enable=0 (any time, including mid-frame):
  - c <= 0, shreg <= 0, sdata <= 0, lrclk <= 0.
  - bclk_q still tracks bclk.
  - The holding register keeps its contents and still accepts frames.
- On re-enable, the first fall is a c=0 frame load.

## Timing
- Reset values:
  - s_ready=1, sdata=0, lrclk=0, underrun=0.
  - c=0, shreg=0, bclk_q=0, holding register empty.
- Reset mid-frame discards the holding register and the in-flight frame.
- Latency: sdata/lrclk change 1 clk after bclk is first sampled low, i.e. 2 clk after the divider's internal falling toggle. They are stable across the following bclk rising edge, which the receiver samples.
- underrun is asserted for exactly the clk cycle in which the c=0 load registers.
- s_ready falls the cycle after an accept. It rises the cycle after the c=0 load.
- Frame period = 2*SLOT_WIDTH bclk periods; one frame is consumed per period.
- A rising bclk edge has no effect.
- bclk that stays constant freezes all outputs.

## Configuration
- I2S_TX_UNDERRUN_REPEAT_EN defined:
  - A last-frame register holds the most recent frame loaded from the holding register.
  - On underrun, the substitute frame is that last frame (repeat).
  - The last-frame register resets to zero.
- Undefined: the substitute frame is all zeros (silence), and no last-frame register exists.
- underrun pulses in both builds.

## Test plan
- Bench settings: SAMPLE_WIDTH=24, SLOT_WIDTH=32, divider factor 8.
- Single frame:
  - Stimulus: accept left=0x800001, right=0x7FFFFE, then enable.
  - Required: sdata bits at c=1..24 are 1,0…0,1; c=25..32 are 0; lrclk=1 from c=32. Right MSB 0 appears at c=33, bits 0x7FFFFE at c=33..56.
- Back-to-back streaming:
  - Stimulus: s_valid held high with incrementing samples.
  - Required: no underrun pulse; s_ready high 1 clk after each c=0 load; every frame serialized in order.
- Underrun:
  - Stimulus: no frame presented at the second boundary.
  - Required, macro undefined: one underrun pulse and 64 bit clocks of zeros.
  - Required, I2S_TX_UNDERRUN_REPEAT_EN: the previous frame repeats bit-exactly.
- Simultaneous:
  - Stimulus: s_valid rises in the same cycle as a c=0 fall with the register empty.
  - Required: underrun pulses, and the frame appears in the following frame.
- Enable drop mid-frame:
  - Stimulus: deassert enable at c=40, re-assert later.
  - Required: sdata=lrclk=0 while disabled; a held frame is preserved and output starting at c=1 after re-enable.
- Reset mid-frame:
  - Stimulus: pulse rst at c=20 with the holding register full.
  - Required: all outputs at reset values the next cycle, s_ready=1, the held frame is never transmitted.
